inference_sequencer: RTL and testbench

Sequences one rank-order-coded inference at a time. It launches the ROC encoder on a loaded input image and watches the core's output AER spikes. It declares the first valid output spike the winning class, or flags a timeout, then stops the encoder and hands the result to the host. It sits between the image buffer/host interface, the ROC encoder and the output side of the SNN core.

---
 rtl/inference_sequencer.sv | 148 ++++++++++++++
 tb/tb_inference_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_sequencer.sv
// Runs one rank-order-coded inference at a time: launches the encoder, takes the first
// in-range output spike as the winning class (or times out), drains the encoder, reports.
//   state       | meaning
//   IDLE        | waiting for START/CONTINUOUS with an image loaded and encoder idle
//   LAUNCH      | one-cycle NEW_IMAGE pulse, counter and winner cleared
//   WAIT_ACCEPT | waiting for the encoder to drop RDY; timeout still counts
//   RUN         | capture armed; first class spike or timeout decides
//   DRAIN       | INFERENCE_RDY held until the encoder is idle again
//   DONE        | result published, image released, count bumped
module inference_sequencer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMEOUT_BITS   = $clog2(TIMEOUT_CYCLES + 1),
  parameter int N_CLASSES      = 10,
  parameter int CLASS_BITS     = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  CONTINUOUS,
  input  logic                  IMAGE_VALID,
  output logic                  IMAGE_CONSUMED,
  input  logic                  ENCODER_RDY,
  output logic                  NEW_IMAGE,
  output logic                  INFERENCE_RDY,
  input  logic                  SPIKE_VALID,
  input  logic [CLASS_BITS-1:0] SPIKE_ID,
  output logic                  BUSY,
  output logic [CLASS_BITS-1:0] RESULT,
  output logic                  RESULT_VALID,
  output logic                  TIMEOUT,
  output logic [15:0]           IMAGE_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_ACCEPT, S_RUN, S_DRAIN, S_DONE
  } state_t;

  localparam logic [TIMEOUT_BITS-1:0] TERM_CNT  = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [CLASS_BITS-1:0]   N_CLS     = CLASS_BITS'(N_CLASSES);

  state_t                  state_q, state_d;
  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;
  logic [CLASS_BITS-1:0]   winner_q, winner_d;
  logic                    flag_q, flag_d;
  logic [CLASS_BITS-1:0]   result_q, result_d;
  logic                    timeout_q, timeout_d;
  logic [15:0]             count_q, count_d;
  logic                    new_image_q, inf_rdy_q, done_q;

  logic [TIMEOUT_BITS-1:0] cnt_inc;
  logic                    at_term;
  logic                    spike_hit;

  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign at_term   = (cnt_q == TERM_CNT);
  assign spike_hit = SPIKE_VALID && (SPIKE_ID < N_CLS);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    winner_d  = winner_q;
    flag_d    = flag_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE: begin
        if ((START || CONTINUOUS) && IMAGE_VALID && ENCODER_RDY) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        cnt_d    = '0;
        winner_d = '0;
        flag_d   = 1'b0;
        state_d  = S_WAIT_ACCEPT;
      end
      S_WAIT_ACCEPT: begin
        cnt_d = cnt_inc;
        if (at_term) begin
          winner_d = '1;
          flag_d   = 1'b1;
          state_d  = S_DRAIN;
        end else if (!ENCODER_RDY) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        // A spike on the terminal-count cycle still wins over the timeout.
        if (spike_hit) begin
          winner_d = SPIKE_ID;
          flag_d   = 1'b0;
          state_d  = S_DRAIN;
        end else if (at_term) begin
          winner_d = '1;
          flag_d   = 1'b1;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ENCODER_RDY) begin
          result_d  = winner_q;
          timeout_d = flag_q;
          count_d   = count_q + 16'd1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pulse/level outputs come from their own flops so they never glitch on state decode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      winner_q    <= '0;
      flag_q      <= 1'b0;
      result_q    <= '0;
      timeout_q   <= 1'b0;
      count_q     <= '0;
      new_image_q <= 1'b0;
      inf_rdy_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      winner_q    <= winner_d;
      flag_q      <= flag_d;
      result_q    <= result_d;
      timeout_q   <= timeout_d;
      count_q     <= count_d;
      new_image_q <= (state_d == S_LAUNCH);
      inf_rdy_q   <= (state_d == S_DRAIN);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign BUSY           = (state_q != S_IDLE);
  assign NEW_IMAGE      = new_image_q;
  assign INFERENCE_RDY  = inf_rdy_q;
  assign RESULT_VALID   = done_q;
  assign IMAGE_CONSUMED = done_q;
  assign RESULT         = result_q;
  assign TIMEOUT        = timeout_q;
  assign IMAGE_COUNT    = count_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: scripted encoder/spike scenarios, outputs predicted per
// inference from launch-relative offsets (accept, decision, drain end) and checked every cycle.
module tb_inference_sequencer;
  localparam int T = 100;
  localparam int N = 10;

  logic        CLK = 1'b0;
  logic        RST, START, CONTINUOUS, IMAGE_VALID, ENCODER_RDY, SPIKE_VALID;
  logic [3:0]  SPIKE_ID;
  logic        IMAGE_CONSUMED, NEW_IMAGE, INFERENCE_RDY, BUSY, RESULT_VALID, TIMEOUT;
  logic [3:0]  RESULT;
  logic [15:0] IMAGE_COUNT;

  inference_sequencer #(.TIMEOUT_CYCLES(T), .N_CLASSES(N), .CLASS_BITS(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CONTINUOUS(CONTINUOUS),
    .IMAGE_VALID(IMAGE_VALID), .IMAGE_CONSUMED(IMAGE_CONSUMED),
    .ENCODER_RDY(ENCODER_RDY), .NEW_IMAGE(NEW_IMAGE), .INFERENCE_RDY(INFERENCE_RDY),
    .SPIKE_VALID(SPIKE_VALID), .SPIKE_ID(SPIKE_ID), .BUSY(BUSY), .RESULT(RESULT),
    .RESULT_VALID(RESULT_VALID), .TIMEOUT(TIMEOUT), .IMAGE_COUNT(IMAGE_COUNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic        e_new, e_irdy, e_busy, e_rv, e_to;
  logic [3:0]  e_res;
  logic [15:0] e_cnt;
  bit          chk_en = 1'b0;
  int          cur_k = -1;
  int          seen_rv_k = -1;
  int          n_new = 0;
  int          n_cons = 0;

  logic [3:0]  m_result;
  logic        m_timeout;
  logic [15:0] m_count;

  bit          sp_v  [0:511];
  logic [3:0]  sp_id [0:511];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("NEW_IMAGE", NEW_IMAGE, e_new);
      chk("INFERENCE_RDY", INFERENCE_RDY, e_irdy);
      chk("BUSY", BUSY, e_busy);
      chk("RESULT_VALID", RESULT_VALID, e_rv);
      chk("IMAGE_CONSUMED", IMAGE_CONSUMED, e_rv);
      chk("RESULT", RESULT, e_res);
      chk("TIMEOUT", TIMEOUT, e_to);
      chk("IMAGE_COUNT", IMAGE_COUNT, e_cnt);
      if (RESULT_VALID === 1'b1) seen_rv_k = cur_k;
      if (NEW_IMAGE === 1'b1) n_new++;
      if (IMAGE_CONSUMED === 1'b1) n_cons++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle_exp();
    e_new = 0; e_irdy = 0; e_busy = 0; e_rv = 0;
    e_res = m_result; e_to = m_timeout; e_cnt = m_count;
    cur_k = -1;
  endtask

  task automatic clear_spikes();
    for (int i = 0; i < 512; i++) begin
      sp_v[i]  = 1'b0;
      sp_id[i] = 4'($urandom_range(0, 15));
    end
  endtask

  // Offsets are cycles after the launch cycle (offset 0 = NEW_IMAGE). The encoder is busy
  // (RDY low) for offsets a..r-1. Decision offset D = first class spike at or after a+1,
  // else T; drain ends at the first offset >= D+1 with RDY high; result shows one later.
  task automatic run_one(input int a, input int r, input bit use_start, input int abort_at);
    int         d, e;
    bit         found;
    logic [3:0] win;
    d = T;
    found = 0;
    for (int j = a + 1; j <= T; j++) begin
      if (sp_v[j] && sp_id[j] < N) begin
        d = j;
        found = 1;
        break;
      end
    end
    e = d + 1;
    while (!(e < a || e >= r)) e++;
    win = found ? sp_id[d] : 4'hF;

    START = use_start; IMAGE_VALID = 1; ENCODER_RDY = 1; SPIKE_VALID = 0;
    set_idle_exp();
    tick();
    START = 0;
    for (int k = 0; k <= e + 1; k++) begin
      if (k == abort_at) begin
        RST = 1; SPIKE_VALID = 0; ENCODER_RDY = 1;
        m_result = 0; m_timeout = 0; m_count = 0;
        set_idle_exp();
        tick();
        RST = 0;
        return;
      end
      ENCODER_RDY = (k == 0) ? 1'b1 : (k < a || k >= r);
      SPIKE_VALID = (k >= 1) ? sp_v[k] : 1'b0;
      SPIKE_ID    = sp_id[k];
      cur_k  = k;
      e_busy = 1;
      e_new  = (k == 0);
      e_irdy = (k >= d + 1 && k <= e);
      e_rv   = (k == e + 1);
      if (k == e + 1) begin
        m_result  = win;
        m_timeout = !found;
        m_count   = m_count + 16'd1;
      end
      e_res = m_result; e_to = m_timeout; e_cnt = m_count;
      tick();
    end
    SPIKE_VALID = 0;
    set_idle_exp();
  endtask

  initial begin
    int nn, nc, a, r, ns;
    RST = 1; START = 0; CONTINUOUS = 0; IMAGE_VALID = 0; ENCODER_RDY = 1;
    SPIKE_VALID = 0; SPIKE_ID = 0;
    m_result = 0; m_timeout = 0; m_count = 0;
    clear_spikes();
    set_idle_exp();
    chk_en = 1;
    tick(); tick();
    RST = 0;
    tick();

    // basic win
    clear_spikes(); sp_v[40] = 1; sp_id[40] = 4'd3;
    run_one(1, 60, 1, -1);
    chk("basic_result", RESULT, 3);
    chk("basic_timeout", TIMEOUT, 0);
    chk("basic_count", IMAGE_COUNT, 1);
    chk("basic_rv_offset", seen_rv_k, 61);

    // out-of-range id ignored, spike during accept wait ignored
    clear_spikes();
    sp_v[5] = 1;  sp_id[5] = 4'd2;
    sp_v[20] = 1; sp_id[20] = 4'd12;
    sp_v[30] = 1; sp_id[30] = 4'd7;
    run_one(10, 50, 1, -1);
    chk("filter_result", RESULT, 7);

    // pure timeout, encoder already idle
    clear_spikes();
    run_one(1, 40, 1, -1);
    chk("timeout_result", RESULT, 4'hF);
    chk("timeout_flag", TIMEOUT, 1);
    chk("timeout_rv_offset", seen_rv_k, 102);

    // spike on the terminal-count cycle
    clear_spikes(); sp_v[100] = 1; sp_id[100] = 4'd5;
    run_one(1, 40, 1, -1);
    chk("tie_result", RESULT, 5);
    chk("tie_flag", TIMEOUT, 0);

    // encoder finishes before any spike
    clear_spikes(); sp_v[80] = 1; sp_id[80] = 4'd9;
    run_one(1, 50, 1, -1);
    chk("encfirst_result", RESULT, 9);
    chk("encfirst_rv_offset", seen_rv_k, 82);

    // START without an image is dropped
    nn = n_new;
    IMAGE_VALID = 0; START = 1; ENCODER_RDY = 1;
    set_idle_exp();
    tick();
    START = 0;
    repeat (3) tick();
    IMAGE_VALID = 1;
    repeat (3) tick();
    chk("dropped_start_launches", n_new - nn, 0);

    // continuous mode, three back-to-back images
    nn = n_new; nc = n_cons;
    CONTINUOUS = 1;
    for (int i = 0; i < 3; i++) begin
      clear_spikes(); sp_v[10] = 1; sp_id[10] = 4'(i + 1);
      run_one(1 + i, 20 + i, 0, -1);
    end
    CONTINUOUS = 0;
    repeat (3) tick();
    chk("cont_new_pulses", n_new - nn, 3);
    chk("cont_consumed_pulses", n_cons - nc, 3);
    chk("cont_count", IMAGE_COUNT, 8);
    chk("cont_result", RESULT, 3);

    // reset in the middle of RUN, then a normal run
    clear_spikes();
    run_one(1, 1000, 1, 50);
    chk("rst_count", IMAGE_COUNT, 0);
    chk("rst_result", RESULT, 0);
    clear_spikes(); sp_v[15] = 1; sp_id[15] = 4'd4;
    run_one(1, 30, 1, -1);
    chk("post_rst_result", RESULT, 4);
    chk("post_rst_count", IMAGE_COUNT, 1);

    // randomized inferences
    for (int it = 0; it < 14; it++) begin
      clear_spikes();
      a = ($urandom_range(0, 4) == 0) ? int'($urandom_range(90, 115)) : int'($urandom_range(1, 6));
      r = a + int'($urandom_range(1, 120));
      ns = int'($urandom_range(0, 4));
      for (int s = 0; s < ns; s++) begin
        int off;
        off = int'($urandom_range(1, 110));
        sp_v[off]  = 1;
        sp_id[off] = 4'($urandom_range(0, 15));
      end
      run_one(a, r, 1, -1);
      repeat (int'($urandom_range(0, 2))) tick();
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
